// File: rtl/alu_ctrl_pipe.sv
// Registered, handshaked ALU control decoder between ID and EX; shift (and MUL) ops occupy EX for SHIFT_CYCLES.
// Optional MUL decode (ALUOp 10, Funct 11, opc 0001) is enabled by defining ALU_CTRL_MUL_EN.
module alu_ctrl_pipe #(
  parameter int unsigned OPCODE_W     = 4,
  parameter int unsigned SHIFT_CYCLES = 2,
  parameter int unsigned ERR_CNT_W    = 8
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           ALUOp,
  input  logic [1:0]           Funct,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           Operacioni,
  output logic                 is_shift,
  output logic                 illegal,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned CNT_W = (SHIFT_CYCLES > 1) ? $clog2(SHIFT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SHIFT_CYCLES - 1);
  localparam bit MULTI_EN = (SHIFT_CYCLES > 1);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  typedef struct packed {
    logic [3:0] op;
    logic       shift;
    logic       illegal;
    logic       multi;
  } dec_t;

  state_t     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic       load;
  logic       accept;
  logic       hi_zero;
  logic [3:0] opc;
  dec_t       dec;

  // Opcode bits above [3] must be zero for any opcode-qualified match.
  assign hi_zero = ((opcode >> 4) == '0);
  assign opc     = opcode[3:0];

  // Decode table; anything unmatched falls through as illegal with op 0000.
  always_comb begin
    dec = '{op: 4'b0000, shift: 1'b0, illegal: 1'b1, multi: 1'b0};
    case (ALUOp)
      2'b00: dec = '{op: 4'b0100, shift: 1'b0, illegal: 1'b0, multi: 1'b0};
      2'b01: dec = '{op: 4'b1100, shift: 1'b0, illegal: 1'b0, multi: 1'b0};
      2'b10: begin
        case (Funct)
          2'b00: begin
            if (hi_zero && opc == 4'b0000)
              dec = '{op: 4'b0000, shift: 1'b0, illegal: 1'b0, multi: 1'b0};
            else if (hi_zero && opc == 4'b0001)
              dec = '{op: 4'b0100, shift: 1'b0, illegal: 1'b0, multi: 1'b0};
          end
          2'b01: begin
            if (hi_zero && opc == 4'b0000)
              dec = '{op: 4'b0010, shift: 1'b0, illegal: 1'b0, multi: 1'b0};
            else if (hi_zero && opc == 4'b0001)
              dec = '{op: 4'b1100, shift: 1'b0, illegal: 1'b0, multi: 1'b0};
          end
          2'b10: dec = '{op: 4'b0011, shift: 1'b0, illegal: 1'b0, multi: 1'b0};
          default: begin
`ifdef ALU_CTRL_MUL_EN
            if (hi_zero && opc == 4'b0001)
              dec = '{op: 4'b1000, shift: 1'b0, illegal: 1'b0, multi: 1'b1};
`endif
          end
        endcase
      end
      default: begin
        if (hi_zero && opc == 4'b1001)
          dec = '{op: 4'b0100, shift: 1'b0, illegal: 1'b0, multi: 1'b0};
        else if (hi_zero && opc == 4'b1010)
          dec = '{op: 4'b1101, shift: 1'b0, illegal: 1'b0, multi: 1'b0};
        else if (hi_zero && opc == 4'b1011)
          dec = '{op: 4'b0001, shift: 1'b0, illegal: 1'b0, multi: 1'b0};
        else if (hi_zero && opc == 4'b0010 && Funct == 2'b00)
          dec = '{op: 4'b0110, shift: 1'b1, illegal: 1'b0, multi: 1'b1};
        else if (hi_zero && opc == 4'b0010 && Funct == 2'b01)
          dec = '{op: 4'b0111, shift: 1'b1, illegal: 1'b0, multi: 1'b1};
      end
    endcase
  end

  // Flush blocks acceptance so a squashed request never enters the stage.
  assign in_ready = !flush && ((state == EMPTY) || (state == FULL && out_ready));
  assign accept   = in_valid && in_ready;

  // Next-state logic
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) load = 1'b1;
        end
        BUSY: begin
          cnt_n = cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) state_n = FULL;
        end
        FULL: begin
          if (out_ready) begin
            if (accept) load = 1'b1;
            else        state_n = EMPTY;
          end
        end
        default: state_n = EMPTY;
      endcase
      if (load) begin
        if (dec.multi && MULTI_EN) begin
          state_n = BUSY;
          cnt_n   = CNT_LOAD;
        end else begin
          state_n = FULL;
        end
      end
    end
  end

  // State, held operation and saturating illegal counter
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= EMPTY;
      cnt        <= '0;
      out_valid  <= 1'b0;
      Operacioni <= 4'b0000;
      is_shift   <= 1'b0;
      illegal    <= 1'b0;
      err_count  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      out_valid <= (state_n == FULL);
      if (load) begin
        Operacioni <= dec.op;
        is_shift   <= dec.shift;
        illegal    <= dec.illegal;
        if (dec.illegal && (err_count != '1))
          err_count <= err_count + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Scoreboard bench for alu_ctrl_pipe: directed decode vectors, stalls, flush, counter saturation and async reset.
`timescale 1ns/1ps
module tb_alu_ctrl_pipe;

  localparam int unsigned OPCODE_W     = 4;
  localparam int unsigned SHIFT_CYCLES = 2;
  localparam int unsigned ERR_CNT_W    = 8;

  logic                 Clock = 1'b0;
  logic                 Reset_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           ALUOp;
  logic [1:0]           Funct;
  logic [OPCODE_W-1:0]  opcode;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0]           Operacioni;
  logic                 is_shift;
  logic                 illegal;
  logic [ERR_CNT_W-1:0] err_count;

  alu_ctrl_pipe #(
    .OPCODE_W(OPCODE_W), .SHIFT_CYCLES(SHIFT_CYCLES), .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .Funct(Funct), .opcode(opcode), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .Operacioni(Operacioni),
    .is_shift(is_shift), .illegal(illegal), .err_count(err_count)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [3:0] op;
    logic       sh;
    logic       il;
    int         lat;
    int         acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   stalls = 0;
  int   first_cyc = 0;
  logic seen = 1'b0;

  always @(posedge Clock) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every EX transfer
  always @(negedge Clock) begin
    if (!Reset_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (!seen) begin
        seen = 1'b1;
        first_cyc = cyc;
      end
      if (out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got op %0h with empty scoreboard", Operacioni);
        end else begin
          mon_e = sb.pop_front();
          chk("operacioni", 32'(Operacioni), 32'(mon_e.op));
          chk("is_shift", 32'(is_shift), 32'(mon_e.sh));
          chk("illegal", 32'(illegal), 32'(mon_e.il));
          chk("latency", 32'(first_cyc - mon_e.acc_cyc), 32'(mon_e.lat));
        end
        seen = 1'b0;
      end
    end else begin
      seen = 1'b0;
    end
  end

  // Called at a rising edge; returns at the edge that accepts the request.
  task automatic send(input logic [1:0] a, input logic [1:0] f, input logic [3:0] o,
                      input logic [3:0] eop, input logic esh, input logic eil, input logic emul);
    int t;
    exp_t e;
    #1;
    in_valid = 1'b1; ALUOp = a; Funct = f; opcode = OPCODE_W'(o);
    @(negedge Clock);
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge Clock);
      t++;
    end
    stalls += t;
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles", t);
    end else begin
      e.op = eop; e.sh = esh; e.il = eil;
      e.lat = emul ? int'(SHIFT_CYCLES) : 1;
      e.acc_cyc = cyc;
      sb.push_back(e);
    end
    @(posedge Clock);
  endtask

  task automatic idle();
    #1;
    in_valid = 1'b0; ALUOp = 2'b00; Funct = 2'b00; opcode = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ill;
    int s0;
    logic [ERR_CNT_W-1:0] ec0;
    Reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    ALUOp = 2'b00; Funct = 2'b00; opcode = '0;
    #1 Reset_n = 1'b0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_operacioni", 32'(Operacioni), 32'd0);
    chk("rst_is_shift", 32'(is_shift), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge Clock) Reset_n = 1'b1;
    @(posedge Clock);

    // Full decode table, back to back with EX always ready
    send(2'b00, 2'b01, 4'b0101, 4'b0100, 1'b0, 1'b0, 1'b0);
    send(2'b01, 2'b11, 4'b1111, 4'b1100, 1'b0, 1'b0, 1'b0);
    send(2'b10, 2'b00, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    send(2'b10, 2'b00, 4'b0001, 4'b0100, 1'b0, 1'b0, 1'b0);
    send(2'b10, 2'b01, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0);
    send(2'b10, 2'b01, 4'b0001, 4'b1100, 1'b0, 1'b0, 1'b0);
    send(2'b10, 2'b10, 4'b0110, 4'b0011, 1'b0, 1'b0, 1'b0);
    send(2'b11, 2'b00, 4'b1001, 4'b0100, 1'b0, 1'b0, 1'b0);
    send(2'b11, 2'b10, 4'b1010, 4'b1101, 1'b0, 1'b0, 1'b0);
    send(2'b11, 2'b11, 4'b1011, 4'b0001, 1'b0, 1'b0, 1'b0);
    send(2'b11, 2'b00, 4'b0010, 4'b0110, 1'b1, 1'b0, 1'b1);
    send(2'b11, 2'b01, 4'b0010, 4'b0111, 1'b1, 1'b0, 1'b1);
    send(2'b11, 2'b10, 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0);
    send(2'b10, 2'b00, 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0);
    send(2'b11, 2'b00, 4'b0111, 4'b0000, 1'b0, 1'b1, 1'b0);
`ifdef ALU_CTRL_MUL_EN
    send(2'b10, 2'b11, 4'b0001, 4'b1000, 1'b0, 1'b0, 1'b1);
    n_ill = 3;
`else
    send(2'b10, 2'b11, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0);
    n_ill = 4;
`endif
    idle();
    chk("err_count_table", 32'(err_count), 32'(n_ill));
    repeat (4) @(posedge Clock);

    // One op per cycle with no stalls
    s0 = stalls;
    repeat (8) send(2'b10, 2'b01, 4'b0001, 4'b1100, 1'b0, 1'b0, 1'b0);
    idle();
    chk("throughput_stalls", 32'(stalls - s0), 32'd0);
    repeat (3) @(posedge Clock);

    // Hold in FULL with EX stalled, then flush with a competing request
    #1 out_ready = 1'b0;
    send(2'b10, 2'b10, 4'b0000, 4'b0011, 1'b0, 1'b0, 1'b0);
    idle();
    repeat (5) begin
      @(negedge Clock);
      chk("hold_operacioni", 32'(Operacioni), 32'h3);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    ec0 = err_count;
    flush = 1'b1; in_valid = 1'b1; ALUOp = 2'b11; Funct = 2'b00; opcode = OPCODE_W'(4'b0111);
    #1 chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge Clock);
    #1;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    chk("flush_err_count", 32'(err_count), 32'(ec0));
    #1 chk("flush_empty_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    @(posedge Clock);

    // Saturating illegal counter
    repeat (300) send(2'b11, 2'b00, 4'b0111, 4'b0000, 1'b0, 1'b1, 1'b0);
    idle();
    chk("err_count_sat", 32'(err_count), 32'd255);
    repeat (3) @(posedge Clock);

    // Async reset while BUSY
    send(2'b11, 2'b00, 4'b0010, 4'b0110, 1'b1, 1'b0, 1'b1);
    idle();
    #1;
    chk("busy_in_ready", 32'(in_ready), 32'd0);
    chk("busy_out_valid", 32'(out_valid), 32'd0);
    chk("busy_operacioni", 32'(Operacioni), 32'h6);
    chk("busy_is_shift", 32'(is_shift), 32'd1);
    Reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_operacioni", 32'(Operacioni), 32'd0);
    chk("arst_is_shift", 32'(is_shift), 32'd0);
    chk("arst_err_count", 32'(err_count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    @(negedge Clock) Reset_n = 1'b1;
    repeat (3) begin
      @(negedge Clock);
      chk("arst_no_pulse", 32'(out_valid), 32'd0);
    end
    @(posedge Clock);

    // Recovery after reset: shift followed by an illegal op
    send(2'b11, 2'b01, 4'b0010, 4'b0111, 1'b1, 1'b0, 1'b1);
    send(2'b11, 2'b00, 4'b0111, 4'b0000, 1'b0, 1'b1, 1'b0);
    idle();
    chk("err_count_after_rst", 32'(err_count), 32'd1);
    repeat (5) @(posedge Clock);
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
